oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- Sequences the OAM DMA transfer started by a CPU write to FF46.
- Copies 160 bytes from source page XX00-XX9F into OAM FE00-FE9F.
- While the copy runs, the block owns the OAM write path and blocks CPU bus access outside HRAM.
- Sits between the CPU MMIO bus, the external-memory read port and the OAM write port, next to the PPU. The PPU's FF46 register becomes read-only shadow data taken from this block.

Parameters:
- CYCLES_PER_BYTE, 4: clocks per transferred byte (one M-cycle); legal range >= 3.
- OAM_BYTES, 160: bytes per transfer.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- ADDR  in  16  CPU bus address
- WR  in  1  CPU write strobe
- MMIO_DATA_out  in  8  CPU write data
- DMA_REG  out  8  last value written to FF46, for readback
- DMA_ACTIVE  out  1  transfer in progress (START or COPY)
- CPU_BLOCK  out  1  high while DMA_ACTIVE and ADDR is outside FF80-FFFE; CPU reads return FF, CPU writes are dropped by the bus
- DMA_RD  out  1  source read strobe
- DMA_SRC_ADDR  out  16  source address
- DMA_DATA_in  in  8  source data, valid one clock after DMA_RD
- OAM_WR  out  1  OAM write strobe
- OAM_ADDR  out  8  OAM offset 0-159
- OAM_DATA  out  8  OAM write data

Behaviour:
- Reset (rst=0, async):
  - DMA_REG=00, DMA_ACTIVE=0, CPU_BLOCK=0, DMA_RD=0, OAM_WR=0.
  - DMA_SRC_ADDR=0000, OAM_ADDR=00, OAM_DATA=00, state IDLE.
  - Reset mid-transfer aborts immediately; OAM keeps any bytes already written.
- Trigger: WR=1 and ADDR=FF46 sampled at a rising edge.
  - DMA_REG takes MMIO_DATA_out.
  - Source page = data, except pages E0-FF, which fold to data-20h (echo RAM).
  - State becomes START, DMA_ACTIVE=1 from the next cycle.
- States:
  - IDLE: no strobes. A trigger moves to START.
  - START: waits CYCLES_PER_BYTE clocks with no strobes, then moves to COPY with byte index n=0.
  - COPY, slot of CYCLES_PER_BYTE clocks per byte n:
    - slot clock 0: DMA_RD=1, DMA_SRC_ADDR={page, n[7:0]}.
    - slot clock 1: latch DMA_DATA_in.
    - slot clock 2: OAM_WR=1, OAM_ADDR=n, OAM_DATA=latched byte.
    - all other slot clocks: idle.
    - After the slot of n=OAM_BYTES-1, go to IDLE and drop DMA_ACTIVE the following cycle.
- Strobes are single-cycle pulses, never asserted in IDLE or START.
- Total DMA_ACTIVE duration = (OAM_BYTES+1)*CYCLES_PER_BYTE clocks = 644 at defaults.
- Restart: a trigger in START or COPY reloads the page and returns to START.
  - Index resets to 0; DMA_ACTIVE stays high with no gap.
  - Any pending OAM write in the current slot is cancelled.
- FF46 writes always update DMA_REG, including while active.
- Counters: the slot counter is log2(CYCLES_PER_BYTE) bits and wraps at CYCLES_PER_BYTE-1; the byte index is 8 bits, terminal 159. Addresses never carry into the page byte.
- CPU_BLOCK is combinational on DMA_ACTIVE and ADDR. FF80-FFFE stays accessible; FFFF is blocked.

Optional Feature:
- Macro: DMA_PPU_LOCK_EN.
- Defined:
  - Adds input PPU_MODE[1:0] and output PPU_OAM_BLOCK.
  - PPU_OAM_BLOCK = DMA_ACTIVE & (PPU_MODE==SCAN(2) or DRAW(3)). The PPU must then treat OAM read data as FF.
  - DMA pauses its slot counter (no strobes) while PPU_MODE==SCAN and the slot clock is 0, giving the PPU OAM scan priority. Total duration grows by the number of stalled clocks.
- Undefined: neither port exists, DMA never stalls, and timing is exactly as above.

Test Plan:
- Reset, then write FF46=C1: DMA_ACTIVE high for 644 clocks; 160 DMA_RD pulses at C100..C19F; 160 OAM_WR pulses at 00..9F, each carrying the byte returned one clock after its read; DMA_REG=C1.
- Write FF46=E3: source addresses C300..C39F (fold check); DMA_REG=E3.
- Write FF46=C0, then FF46=D0 after 50 OAM writes: OAM_WR stops, START lasts 4 clocks, copying restarts at D000→OAM 00, DMA_ACTIVE never drops; 160 further writes follow.
- During DMA: ADDR=FF90 gives CPU_BLOCK=0; ADDR=C000 or FFFF gives CPU_BLOCK=1; after completion ADDR=C000 gives CPU_BLOCK=0.
- Assert rst=0 mid-COPY (byte 80) asynchronously, between clock edges: all outputs are at reset values before the next edge; after release, no strobes until a new FF46 write.
- With DMA_PPU_LOCK_EN and PPU_MODE held at SCAN for 80 clocks: PPU_OAM_BLOCK=1, no strobes while stalled, and DMA_ACTIVE duration equals 644 plus the stalled clocks.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: a CPU write to FF46 copies 160 bytes from page XX00 into OAM.
// Optional macro DMA_PPU_LOCK_EN adds PPU OAM-scan arbitration (stall + OAM read block).
module oam_dma_ctrl #(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int OAM_BYTES       = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ADDR,
    input  logic        WR,
    input  logic [7:0]  MMIO_DATA_out,
    output logic [7:0]  DMA_REG,
    output logic        DMA_ACTIVE,
    output logic        CPU_BLOCK,
    output logic        DMA_RD,
    output logic [15:0] DMA_SRC_ADDR,
    input  logic [7:0]  DMA_DATA_in,
    output logic        OAM_WR,
    output logic [7:0]  OAM_ADDR,
    output logic [7:0]  OAM_DATA
`ifdef DMA_PPU_LOCK_EN
    ,
    input  logic [1:0]  PPU_MODE,
    output logic        PPU_OAM_BLOCK
`endif
);

    localparam int SLOT_W = $clog2(CYCLES_PER_BYTE);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CYCLES_PER_BYTE - 1);
    localparam logic [SLOT_W-1:0] SLOT_RD   = SLOT_W'(0);
    localparam logic [SLOT_W-1:0] SLOT_LAT  = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_WR   = SLOT_W'(2);
    localparam logic [7:0]        IDX_LAST  = 8'(OAM_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_COPY} state_t;

    state_t            state_reg, state_next;
    logic [SLOT_W-1:0] slot_reg, slot_next;
    logic [7:0]        idx_reg, idx_next;
    logic [7:0]        page_reg, page_next;
    logic [7:0]        data_reg, data_next;
    logic [7:0]        dma_reg_reg, dma_reg_next;
    logic              trigger;
    logic              stall;

    assign trigger = WR && (ADDR == 16'hFF46);

`ifdef DMA_PPU_LOCK_EN
    // OAM scan wins only at a slot boundary, so a started read/latch/write slot is never split
    assign stall         = (state_reg == S_COPY) && (PPU_MODE == 2'd2) && (slot_reg == SLOT_RD);
    assign PPU_OAM_BLOCK = DMA_ACTIVE && PPU_MODE[1];
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            slot_reg    <= '0;
            idx_reg     <= '0;
            page_reg    <= '0;
            data_reg    <= '0;
            dma_reg_reg <= '0;
        end else begin
            state_reg   <= state_next;
            slot_reg    <= slot_next;
            idx_reg     <= idx_next;
            page_reg    <= page_next;
            data_reg    <= data_next;
            dma_reg_reg <= dma_reg_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        slot_next    = slot_reg;
        idx_next     = idx_reg;
        page_next    = page_reg;
        data_next    = data_reg;
        dma_reg_next = dma_reg_reg;
        DMA_RD       = 1'b0;
        OAM_WR       = 1'b0;

        case (state_reg)
            S_START: begin
                if (slot_reg == SLOT_LAST) begin
                    state_next = S_COPY;
                    slot_next  = '0;
                    idx_next   = '0;
                end else begin
                    slot_next = slot_reg + SLOT_W'(1);
                end
            end
            S_COPY: begin
                if (!stall) begin
                    DMA_RD = (slot_reg == SLOT_RD);
                    OAM_WR = (slot_reg == SLOT_WR);
                    if (slot_reg == SLOT_LAT)
                        data_next = DMA_DATA_in;
                    if (slot_reg == SLOT_LAST) begin
                        slot_next = '0;
                        if (idx_reg == IDX_LAST)
                            state_next = S_IDLE;
                        else
                            idx_next = idx_reg + 8'd1;
                    end else begin
                        slot_next = slot_reg + SLOT_W'(1);
                    end
                end
            end
            default: ;
        endcase

        // A trigger in any state (re)starts; going to START drops any write not yet issued
        if (trigger) begin
            dma_reg_next = MMIO_DATA_out;
            page_next    = (MMIO_DATA_out >= 8'hE0) ? (MMIO_DATA_out - 8'h20) : MMIO_DATA_out;
            state_next   = S_START;
            slot_next    = '0;
            idx_next     = '0;
        end
    end

    assign DMA_ACTIVE   = (state_reg != S_IDLE);
    assign CPU_BLOCK    = DMA_ACTIVE && !((ADDR >= 16'hFF80) && (ADDR != 16'hFFFF));
    assign DMA_SRC_ADDR = {page_reg, idx_reg};
    assign OAM_ADDR     = idx_reg;
    assign OAM_DATA     = data_reg;
    assign DMA_REG      = dma_reg_reg;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl: cycle-accurate scoreboard of expected DMA reads,
// OAM writes and the active window, derived from the transfer rules and a source memory image.
module tb_oam_dma_ctrl;

    localparam int CPB   = 4;
    localparam int NBYTE = 160;
    localparam int DUR   = (NBYTE + 1) * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] ADDR = 16'h0000;
    logic        WR = 1'b0;
    logic [7:0]  MMIO_DATA_out = 8'h00;
    logic [7:0]  DMA_REG;
    logic        DMA_ACTIVE;
    logic        CPU_BLOCK;
    logic        DMA_RD;
    logic [15:0] DMA_SRC_ADDR;
    logic [7:0]  DMA_DATA_in = 8'h00;
    logic        OAM_WR;
    logic [7:0]  OAM_ADDR;
    logic [7:0]  OAM_DATA;
`ifdef DMA_PPU_LOCK_EN
    logic [1:0]  PPU_MODE = 2'd0;
    logic        PPU_OAM_BLOCK;
`endif

    oam_dma_ctrl #(.CYCLES_PER_BYTE(CPB), .OAM_BYTES(NBYTE)) dut (
        .clk(clk), .rst(rst), .ADDR(ADDR), .WR(WR), .MMIO_DATA_out(MMIO_DATA_out),
        .DMA_REG(DMA_REG), .DMA_ACTIVE(DMA_ACTIVE), .CPU_BLOCK(CPU_BLOCK),
        .DMA_RD(DMA_RD), .DMA_SRC_ADDR(DMA_SRC_ADDR), .DMA_DATA_in(DMA_DATA_in),
        .OAM_WR(OAM_WR), .OAM_ADDR(OAM_ADDR), .OAM_DATA(OAM_DATA)
`ifdef DMA_PPU_LOCK_EN
        , .PPU_MODE(PPU_MODE), .PPU_OAM_BLOCK(PPU_OAM_BLOCK)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [15:0] a;
        logic [7:0]  d;
    } ev_t;

    logic [7:0]  mem [0:65535];
    ev_t         rd_q[$];
    ev_t         wr_q[$];
    int unsigned cyc = 0;
    int unsigned act_start = 1;
    int unsigned act_end = 0;
    logic [7:0]  exp_reg = 8'h00;
    bit          rd_prev_v = 1'b0;
    logic [15:0] rd_prev_a = 16'h0000;
    int          wr_seen = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit exp_active(input int unsigned c);
        return (c >= act_start) && (c <= act_end);
    endfunction

    // Model of one FF46 write seen at the edge ending cycle cyc
    task automatic schedule(input logic [7:0] d);
        logic [7:0] fp;
        ev_t e;
        fp = (d >= 8'hE0) ? d - 8'h20 : d;
        if (!exp_active(cyc)) act_start = cyc + 1;
        act_end = cyc + DUR;
        while (rd_q.size() > 0 && rd_q[$].cyc > cyc) void'(rd_q.pop_back());
        while (wr_q.size() > 0 && wr_q[$].cyc > cyc) void'(wr_q.pop_back());
        for (int n = 0; n < NBYTE; n++) begin
            e.cyc = cyc + CPB + 1 + CPB * n;
            e.a   = {fp, 8'(n)};
            e.d   = 8'h00;
            rd_q.push_back(e);
            e.cyc = cyc + CPB + 3 + CPB * n;
            e.a   = {8'h00, 8'(n)};
            e.d   = mem[{fp, 8'(n)}];
            wr_q.push_back(e);
        end
    endtask

    task automatic step(input bit trig, input logic [7:0] d);
        logic [15:0] a;
        bit ea, er, ew;
        @(negedge clk);
        cyc++;
        ea = exp_active(cyc);
        check_val("dma_active", DMA_ACTIVE, ea);
        check_val("dma_reg", DMA_REG, exp_reg);
        er = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
        check_val("dma_rd", DMA_RD, er);
        if (er && DMA_RD) check_val("src_addr", DMA_SRC_ADDR, rd_q[0].a);
        if (er) void'(rd_q.pop_front());
        ew = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
        check_val("oam_wr", OAM_WR, ew);
        if (ew && OAM_WR) begin
            check_val("oam_addr", OAM_ADDR, wr_q[0].a[7:0]);
            check_val("oam_data", OAM_DATA, wr_q[0].d);
        end
        if (ew) void'(wr_q.pop_front());
        if (OAM_WR) wr_seen++;
        DMA_DATA_in = rd_prev_v ? mem[rd_prev_a] : 8'($urandom);
        rd_prev_v = DMA_RD;
        rd_prev_a = DMA_SRC_ADDR;
        if (trig) begin
            a = 16'hFF46;
            WR = 1'b1;
            MMIO_DATA_out = d;
            exp_reg = d;
            schedule(d);
        end else begin
            case ($urandom_range(0, 6))
                0: a = 16'hFF90;
                1: a = 16'hC000;
                2: a = 16'hFFFF;
                3: a = 16'hFF80;
                4: a = 16'hFFFE;
                5: a = 16'hFF7F;
                default: a = 16'($urandom);
            endcase
            WR = 1'b0;
            MMIO_DATA_out = 8'($urandom);
        end
        ADDR = a;
        #1;
        check_val("cpu_block", CPU_BLOCK, ea && !((a >= 16'hFF80) && (a <= 16'hFFFE)));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_dma_reg"}, DMA_REG, 8'h00);
        check_val({tag, "_active"}, DMA_ACTIVE, 1'b0);
        check_val({tag, "_cpu_block"}, CPU_BLOCK, 1'b0);
        check_val({tag, "_dma_rd"}, DMA_RD, 1'b0);
        check_val({tag, "_oam_wr"}, OAM_WR, 1'b0);
        check_val({tag, "_src_addr"}, DMA_SRC_ADDR, 16'h0000);
        check_val({tag, "_oam_addr"}, OAM_ADDR, 8'h00);
        check_val({tag, "_oam_data"}, OAM_DATA, 8'h00);
    endtask

    task automatic run_transfer(input logic [7:0] pg);
        wr_seen = 0;
        step(1'b1, pg);
        for (int i = 0; i < DUR + 12; i++) step(1'b0, 8'h00);
        check_val("wr_count", wr_seen, NBYTE);
        check_val("rd_left", rd_q.size(), 0);
        check_val("wr_left", wr_q.size(), 0);
        $display("transfer page %02h: %0d OAM writes, DMA_REG=%02h", pg, wr_seen, DMA_REG);
    endtask

    task automatic wait_writes(input int target, input string tag);
        for (int i = 0; i < 4000 && wr_seen < target; i++) step(1'b0, 8'h00);
        check_val(tag, wr_seen >= target, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        // Power-up reset
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        check_reset_outputs("por");
        rst = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00);

        run_transfer(8'hC1);
        run_transfer(8'hE3);
        run_transfer(8'($urandom_range(0, 255)));
        run_transfer(8'($urandom_range(8'hE0, 8'hFF)));

        // Restart mid-copy after 50 OAM writes
        wr_seen = 0;
        step(1'b1, 8'hC0);
        wait_writes(50, "wait_wr50");
        step(1'b1, 8'hD0);
        for (int i = 0; i < DUR + 12; i++) step(1'b0, 8'h00);
        check_val("restart_wr_count", wr_seen, 50 + NBYTE);
        check_val("restart_rd_left", rd_q.size(), 0);
        check_val("restart_wr_left", wr_q.size(), 0);
        $display("restart C0->D0: %0d OAM writes total", wr_seen);

        // Asynchronous reset between clock edges during byte 80
        wr_seen = 0;
        step(1'b1, 8'($urandom_range(0, 255)));
        wait_writes(80, "wait_wr80");
        #2 rst = 1'b0;
        #1 check_reset_outputs("async");
        rd_q.delete();
        wr_q.delete();
        act_start = 1;
        act_end = 0;
        exp_reg = 8'h00;
        rd_prev_v = 1'b0;
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        rst = 1'b1;
        wr_seen = 0;
        for (int i = 0; i < DUR + 12; i++) step(1'b0, 8'h00);
        check_val("post_reset_writes", wr_seen, 0);
        $display("async reset mid-copy: %0d writes after release", wr_seen);

`ifdef DMA_PPU_LOCK_EN
        check_val("ppu_oam_block_idle", PPU_OAM_BLOCK, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
